// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter sharing one external 2:1 mux between two requesters,
// with a one-entry registered output stage and valid/ready toward the consumer.
module mux3_rr_arbiter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned BURST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    output logic             ack_a,
    input  logic             req_b,
    output logic             ack_b,
    output logic             mux_sel,
    input  logic [WIDTH-1:0] mux_o,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             last_grant
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_d;
    logic               last_grant_d;
    logic               any_req;
    logic               winner;
    logic               can_accept;
    logic               transfer;

    // Arbitration, handshake and next-state decode
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        burst_cnt_d  = burst_cnt;
        last_grant_d = last_grant;
        winner       = 1'b0;
        any_req      = req_a | req_b;
        can_accept   = (state_q == EMPTY) | out_ready;

        if (req_a && req_b) begin
            winner = (burst_cnt < BURST_C) ? last_grant : ~last_grant;
        end else begin
            winner = req_b;
        end

        // Reset gates the combinational outputs so nothing is acked while held
        transfer = rst_n & any_req & can_accept;
        ack_a    = transfer & ~winner;
        ack_b    = transfer & winner;
        mux_sel  = rst_n & (any_req ? winner : last_grant);

        case (state_q)
            EMPTY: if (transfer) state_d = FULL;
            FULL:  if (out_ready && !transfer) state_d = EMPTY;
        endcase

        if (transfer) begin
            data_d       = mux_o;
            last_grant_d = winner;
            if ((winner == last_grant) && (burst_cnt != '0)) begin
                burst_cnt_d = (burst_cnt >= BURST_C) ? BURST_C : burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            data_q     <= '0;
            burst_cnt  <= '0;
            last_grant <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            burst_cnt  <= burst_cnt_d;
            last_grant <= last_grant_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;

endmodule
